// File: rtl/add_serial.sv
// Digit-serial 32-bit adder: adds DIGIT_W bits per cycle over NDIG cycles and
// registers the sum, unsigned carry-out and signed overflow on completion.
module add_serial #(
  parameter int unsigned DIGIT_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        cout,
  output logic        ovf,
  output logic        busy,
  output logic        done
);

  localparam int unsigned NDIG = 32 / DIGIT_W;
  localparam int unsigned CntW = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e              state_q, state_d;
  logic [31:0]         a_sh_q, a_sh_d;
  logic [31:0]         b_sh_q, b_sh_d;
  logic [31:0]         sum_q, sum_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                carry_q, carry_d;
  logic                a_msb_q, a_msb_d;
  logic                b_msb_q, b_msb_d;
  logic [31:0]         result_q, result_d;
  logic                cout_q, cout_d;
  logic                ovf_q, ovf_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [DIGIT_W:0]    slice_sum;
  logic [31+DIGIT_W:0] sum_cat;
  logic [31:0]         sum_shift;
  logic                last_slice;

  always_comb begin
    slice_sum  = {1'b0, a_sh_q[DIGIT_W-1:0]} + {1'b0, b_sh_q[DIGIT_W-1:0]}
               + {{DIGIT_W{1'b0}}, carry_q};
    // New slice enters at the top; after NDIG slices the sum sits right-aligned.
    sum_cat    = {slice_sum[DIGIT_W-1:0], sum_q};
    sum_shift  = sum_cat[31+DIGIT_W:DIGIT_W];
    last_slice = (cnt_q == CntW'(NDIG - 1));

    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_d    = sum_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StRun;
          a_sh_d  = a;
          b_sh_d  = b;
          a_msb_d = a[31];
          b_msb_d = b[31];
          sum_d   = '0;
          cnt_d   = '0;
          carry_d = 1'b0;
          busy_d  = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        a_sh_d  = a_sh_q >> DIGIT_W;
        b_sh_d  = b_sh_q >> DIGIT_W;
        sum_d   = sum_shift;
        carry_d = slice_sum[DIGIT_W];
        cnt_d   = cnt_q + CntW'(1);
        if (last_slice) begin
          state_d  = StDone;
          result_d = sum_shift;
          cout_d   = slice_sum[DIGIT_W];
          ovf_d    = (a_msb_q == b_msb_q) && (sum_shift[31] != a_msb_q);
          done_d   = 1'b1;
        end else begin
          busy_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_q    <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_q    <= sum_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign result = result_q;
  assign cout   = cout_q;
  assign ovf    = ovf_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_add_serial.sv
// Bench for add_serial: three instances (DIGIT_W = 4, 1, 32) checked against a
// scoreboard of expected sums pushed at launch and popped on each done pulse.
module tb_add_serial;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a, b;
  logic [2:0]  st, bz, dn, co, ov;
  logic [31:0] res [3];

  always #5 clk = ~clk;

  add_serial #(.DIGIT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(st[0]), .a(a), .b(b),
    .result(res[0]), .cout(co[0]), .ovf(ov[0]), .busy(bz[0]), .done(dn[0])
  );
  add_serial #(.DIGIT_W(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(st[1]), .a(a), .b(b),
    .result(res[1]), .cout(co[1]), .ovf(ov[1]), .busy(bz[1]), .done(dn[1])
  );
  add_serial #(.DIGIT_W(32)) u_dut32 (
    .clk(clk), .rst(rst), .start(st[2]), .a(a), .b(b),
    .result(res[2]), .cout(co[2]), .ovf(ov[2]), .busy(bz[2]), .done(dn[2])
  );

  typedef struct packed {
    logic [31:0] res;
    logic        co;
    logic        ov;
  } exp_t;

  exp_t        sb [$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] held [3];

  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y);
    exp_t        e;
    logic [32:0] s;
    s    = {1'b0, x} + {1'b0, y};
    e.res = s[31:0];
    e.co  = s[32];
    e.ov  = (x[31] == y[31]) && (s[31] != x[31]);
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive start for one edge, then scramble the operands to prove they were captured.
  task automatic launch(input int sel, input logic [31:0] x, input logic [31:0] y,
                        input bit push);
    a = x;
    b = y;
    st[sel] = 1'b1;
    if (push) sb.push_back(model(x, y));
    tick();
    st[sel] = 1'b0;
    a = $urandom;
    b = $urandom;
  endtask

  task automatic wait_done(input int sel, input int nbusy, input string name);
    int   busy_n = 0;
    int   cyc = 0;
    bit   held_ok = 1'b1;
    exp_t e;
    while (dn[sel] !== 1'b1 && cyc < 200) begin
      if (bz[sel] === 1'b1) busy_n++;
      if (res[sel] !== held[sel]) held_ok = 1'b0;
      tick();
      cyc++;
    end
    checks++;
    if (dn[sel] !== 1'b1) begin
      errors++;
      $display("FAIL %s timeout: done=%b after %0d cycles, required 1", name, dn[sel], cyc);
      return;
    end
    checks++;
    if (busy_n != nbusy) begin
      errors++;
      $display("FAIL %s busy cycles: got %0d, required %0d", name, busy_n, nbusy);
    end
    checks++;
    if (!held_ok) begin
      errors++;
      $display("FAIL %s result hold: changed during run, required %h", name, held[sel]);
    end
    checks++;
    if (bz[sel] !== 1'b0) begin
      errors++;
      $display("FAIL %s busy in done: got %b, required 0", name, bz[sel]);
    end
    if (sb.size() == 0) e = '0;
    else e = sb.pop_front();
    checks++;
    if ({res[sel], co[sel], ov[sel]} !== {e.res, e.co, e.ov}) begin
      errors++;
      $display("FAIL %s sum: got res=%h cout=%b ovf=%b, required res=%h cout=%b ovf=%b",
               name, res[sel], co[sel], ov[sel], e.res, e.co, e.ov);
    end
    held[sel] = e.res;
    tick();
    checks++;
    if (dn[sel] !== 1'b0) begin
      errors++;
      $display("FAIL %s done width: got done=%b one cycle later, required 0", name, dn[sel]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    st  = '0;
    a   = '0;
    b   = '0;
    for (int i = 0; i < 3; i++) held[i] = '0;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({res[i], co[i], ov[i], bz[i], dn[i]} !== 36'h0) begin
        errors++;
        $display("FAIL reset inst%0d: got res=%h cout=%b ovf=%b busy=%b done=%b, required 0",
                 i, res[i], co[i], ov[i], bz[i], dn[i]);
      end
    end
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic test_basic();
    launch(0, 32'h0000_0001, 32'h0000_0000, 1'b1);
    wait_done(0, 8, "basic");
  endtask

  task automatic test_overflow();
    launch(0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1);
    wait_done(0, 8, "signed_ovf");
    launch(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
    wait_done(0, 8, "carry_out");
    launch(0, 32'h8000_0000, 32'h8000_0000, 1'b1);
    wait_done(0, 8, "neg_ovf");
  endtask

  // A start pulse with zero operands mid-run must leave the sum and timing alone.
  task automatic test_ignore_start();
    launch(0, 32'h0000_03F2, 32'h0000_03F2, 1'b1);
    repeat (3) tick();
    a = '0;
    b = '0;
    st[0] = 1'b1;
    tick();
    st[0] = 1'b0;
    wait_done(0, 4, "ignore_start");
  endtask

  task automatic test_back_to_back();
    int   t = 0;
    int   d1 = -1;
    int   d2 = -1;
    exp_t e;
    a = 32'h0000_2775;
    b = 32'h0000_2775;
    st[0] = 1'b1;
    sb.push_back(model(32'h0000_2775, 32'h0000_2775));
    tick();
    a = 32'h0000_2710;
    b = 32'h0000_2710;
    sb.push_back(model(32'h0000_2710, 32'h0000_2710));
    while (d2 < 0 && t < 40) begin
      if (dn[0] === 1'b1) begin
        if (sb.size() == 0) e = '0;
        else e = sb.pop_front();
        checks++;
        if ({res[0], co[0], ov[0]} !== {e.res, e.co, e.ov}) begin
          errors++;
          $display("FAIL b2b sum: got res=%h cout=%b ovf=%b, required res=%h cout=%b ovf=%b",
                   res[0], co[0], ov[0], e.res, e.co, e.ov);
        end
        held[0] = e.res;
        if (d1 < 0) d1 = t;
        else d2 = t;
      end
      tick();
      t++;
      if (d1 >= 0) st[0] = 1'b0;
    end
    st[0] = 1'b0;
    checks++;
    if (d2 < 0 || d2 - d1 != 9) begin
      errors++;
      $display("FAIL b2b spacing: got done at %0d and %0d, required 9 apart", d1, d2);
    end
  endtask

  task automatic test_reset_abort();
    launch(0, 32'h1234_5678, 32'h1111_1111, 1'b0);
    repeat (3) tick();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({res[0], co[0], ov[0], bz[0], dn[0]} !== 36'h0) begin
      errors++;
      $display("FAIL abort async: got res=%h cout=%b ovf=%b busy=%b done=%b, required 0",
               res[0], co[0], ov[0], bz[0], dn[0]);
    end
    tick();
    checks++;
    if (dn[0] !== 1'b0 || bz[0] !== 1'b0) begin
      errors++;
      $display("FAIL abort hold: got busy=%b done=%b, required 0", bz[0], dn[0]);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) held[i] = '0;
    launch(0, 32'h0F0F_0F0F, 32'h0101_0101, 1'b1);
    wait_done(0, 8, "after_abort");
  endtask

  task automatic test_widths();
    launch(1, 32'h0000_0001, 32'h0000_0000, 1'b1);
    wait_done(1, 32, "w1_basic");
    launch(1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1);
    wait_done(1, 32, "w1_ovf");
    launch(1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
    wait_done(1, 32, "w1_carry");
    launch(2, 32'h0000_0001, 32'h0000_0000, 1'b1);
    wait_done(2, 1, "w32_basic");
    launch(2, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1);
    wait_done(2, 1, "w32_ovf");
    launch(2, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
    wait_done(2, 1, "w32_carry");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    test_widths();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/add_serial.md
ADD_SERIAL -- requirements
Module: add_serial

Interface
REQ-001 Parameter DIGIT_W, default 4: adder slice width in bits per cycle; SHALL be one of 1, 2, 4, 8, 16, 32.
REQ-002 Derived constant NDIG = 32/DIGIT_W: number of slice cycles per operation (default 8).
REQ-003 clk  input  1: single clock; all state SHALL change on its rising edge only.
REQ-004 rst  input  1: asynchronous, active-high reset.
REQ-005 start  input  1: request to begin an addition; sampled on the rising edge of clk.
REQ-006 a  input  32: first operand; sampled only on the edge that accepts start.
REQ-007 b  input  32: second operand; sampled only on the edge that accepts start.
REQ-008 result  output  32: registered sum a+b mod 2^32.
REQ-009 cout  output  1: registered unsigned carry out of bit 31.
REQ-010 ovf  output  1: registered two's-complement signed overflow flag.
REQ-011 busy  output  1: high while an operation is in progress.
REQ-012 done  output  1: one-cycle pulse marking result, cout and ovf as newly valid.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN and DONE; the reset state SHALL be IDLE.
REQ-014 IDLE: start=1 at an edge -> capture a and b into internal shift registers, clear the slice counter and internal carry, go to RUN.
REQ-015 IDLE: start=0 -> stay in IDLE.
REQ-016 RUN: each edge SHALL add the low DIGIT_W bits of both shift registers plus the internal carry.
REQ-017 RUN: each edge SHALL shift the slice sum into the top of an internal sum register, shift both operand registers right by DIGIT_W, update the carry and increment the counter.
REQ-018 RUN: on the edge that processes slice NDIG-1, the FSM SHALL go to DONE and load result, cout and ovf from the completed sum in the same edge.
REQ-019 ovf SHALL equal (a[31]==b[31]) AND (result[31]!=a[31]), using the captured operands.
REQ-020 DONE SHALL last exactly one cycle, with done=1 during that cycle.
REQ-021 DONE: start=1 SHALL be accepted exactly as in IDLE (capture, go to RUN), giving back-to-back operations with no idle gap.
REQ-022 DONE: start=0 -> go to IDLE.
REQ-023 busy SHALL be 1 in RUN and 0 in IDLE and DONE.
REQ-024 done SHALL be 1 only in DONE.
REQ-025 Latency: if start is accepted at edge E0, done SHALL be high in the cycle after edge E0+NDIG (default: 8 cycles of busy, then 1 cycle of done).
REQ-026 start while in RUN SHALL be ignored, with no effect on the operands or the timing.
REQ-027 result, cout and ovf SHALL change only on entry to DONE or on reset.
REQ-028 result, cout and ovf SHALL hold their values through IDLE and through the entire next operation.
REQ-029 Changes on a and b after the accepting edge SHALL not affect the operation in progress.

Reset
REQ-030 rst=1 SHALL force IDLE immediately, without waiting for a clock edge.
REQ-031 rst=1 SHALL force result=0, cout=0, ovf=0, busy=0, done=0, and clear the counter, carry and internal registers.
REQ-032 rst asserted mid-RUN SHALL abort the operation: no done pulse and no update of result, cout or ovf.
REQ-033 After rst deasserts, the first start SHALL be accepted on the next rising edge.

Verification
REQ-034 a=0x00000001, b=0x00000000, start pulse -> busy high 8 cycles, then done pulse; result=0x00000001, cout=0, ovf=0.
REQ-035 a=0x7FFFFFFF, b=0x00000001 -> result=0x80000000, cout=0, ovf=1; a=0xFFFFFFFF, b=0x00000001 -> result=0x00000000, cout=1, ovf=0.
REQ-036 a=0x000003F2, b=0x000003F2 (1010 decimal each) -> result=0x000007E4; start re-pulsed with a=b=0 during RUN -> ignored, done still 8 cycles after the first start.
REQ-037 start held high continuously, operands 0x00002775 then 0x00002710 -> two done pulses exactly 9 cycles apart, with correct results.
REQ-038 rst pulsed at RUN cycle 4 -> outputs 0 immediately, no done pulse; new start 1 cycle after rst releases completes normally.
REQ-039 Repeat REQ-034 and REQ-035 with DIGIT_W=1 (32 busy cycles) and DIGIT_W=32 (1 busy cycle) -> identical results and flags.
